// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
// Imported by the receiver, the loader top and its bench.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop rxd synchronizer plus a mid-bit sampling FSM.
// Emits one-cycle byte_valid or frame_err_pulse per received frame.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic sync1, rxs;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_d;
  logic valid_d, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      rx_byte <= '0;
      byte_valid <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      rx_byte <= byte_d;
      byte_valid <= valid_d;
      frame_err_pulse <= ferr_d;
    end
  end

  // Start is confirmed at half a bit, so every later full-bit
  // count lands in the middle of a bit cell.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    byte_d = rx_byte;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == MID) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          shift_d[idx_q] = rxs;
          if (idx_q == 3'd7) state_d = STOP;
          else idx_d = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          state_d = IDLE;
          if (rxs) begin
            valid_d = 1'b1;
            byte_d = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes little-endian into words, writes them to
// sequential imem addresses and releases the core after NUM_WORDS words.
module uart_imem_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NUM_WORDS = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              loading,
  output logic              load_done,
  output logic              frame_err,
  output logic              cpu_rst_n
);

  localparam int IW = $clog2(INSTR_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  logic [7:0] rx_byte;
  logic byte_valid;
  logic frame_err_pulse;
  logic [IW-1:0] idx_q;
  logic [23:0] low_q;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .rxd(rxd),
    .rx_byte(rx_byte),
    .byte_valid(byte_valid),
    .frame_err_pulse(frame_err_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      low_q <= '0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      load_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (frame_err_pulse) frame_err <= 1'b1;
      if (byte_valid) begin
        idx_q <= idx_q + 1'b1;
        unique case (idx_q)
          2'd0: low_q[7:0] <= rx_byte;
          2'd1: low_q[15:8] <= rx_byte;
          2'd2: low_q[23:16] <= rx_byte;
          default: ;
        endcase
        if (idx_q == LAST_IDX && !load_done) begin
          imem_we <= 1'b1;
          imem_wdata <= {rx_byte, low_q};
        end
      end
      // Address parks on the last word instead of wrapping.
      if (imem_we) begin
        if (imem_addr == LAST_ADDR) load_done <= 1'b1;
        else imem_addr <= imem_addr + 1'b1;
      end
    end
  end

  assign loading = ~load_done;
  assign cpu_rst_n = load_done;

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
UART-side boot loader feeding the instruction memory. Receives 8N1 serial bytes on RxD (LSB first, idle high), packs every 4 bytes little-endian into a 32-bit instruction word and writes it to sequential instruction memory word addresses. Holds the core in reset until NUM_WORDS words are loaded, then releases it. Sits in top between the RxD pin and the instruction memory write port.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud)
NUM_WORDS, 64, instruction words to load before releasing the core (256 bytes)
ADDR_W, 6, imem word-address width; must satisfy 2**ADDR_W >= NUM_WORDS

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset (driven from sw[15])
rxd  in  1  UART serial input, asynchronous to clk, idle high
imem_we  out  1  one-cycle write strobe to instruction memory
imem_addr  out  ADDR_W  word address of current write
imem_wdata  out  32  assembled instruction word
loading  out  1  high while load incomplete
load_done  out  1  sticky, high once NUM_WORDS words written
frame_err  out  1  sticky, set on any bad stop bit
cpu_rst_n  out  1  active-low core reset; low until load_done

Behaviour:
- Reset (async, rst_n=0): imem_we=0, imem_addr=0, imem_wdata=0, loading=1, load_done=0, frame_err=0, cpu_rst_n=0. rxd synchronizer flops reset to 1; RX FSM to IDLE; byte index=0; bit counter=0. Reset mid-byte or mid-word discards partial data.
- rxd passes a 2-flop synchronizer; all sampling uses the synchronized value (2-cycle input latency).
- RX FSM states IDLE, START, DATA, STOP:
  - IDLE: synced rxd=0 -> START, baud counter cleared.
  - START: at counter = CLKS_PER_BIT/2-1 (mid start bit) re-sample: 0 -> DATA, counter cleared, bit index 0; 1 -> IDLE (glitch rejected, no byte, no error).
  - DATA: every CLKS_PER_BIT cycles sample one bit into shift register position bit index (LSB first); after bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles sample: 1 -> byte_valid pulse for 1 cycle with the byte; 0 -> frame_err set, byte discarded. Both -> IDLE (return at mid-stop so a back-to-back start edge is caught).
- Word assembly: on byte_valid, byte placed at bits [8*idx+7:8*idx], idx increments mod 4. First byte received = bits [7:0].
- On the 4th byte: next cycle imem_we=1 for exactly one cycle, imem_wdata = full word, imem_addr = current word address. Word address increments the cycle after the strobe. imem_addr/imem_wdata hold their values between strobes.
- Completion: in the cycle after the strobe for word NUM_WORDS-1, load_done=1, loading=0, cpu_rst_n=1; all stay so until reset. Word address does not wrap.
- After load_done: bytes are still received (frame_err still updates) but no imem_we is ever generated.
- Discarded (framing-error) byte does not advance the byte index.
- Byte throughput bounded by UART (10*CLKS_PER_BIT cycles/byte); no back-pressure from imem, which accepts a write every cycle.

Decomposition:
- Package uart_loader_pkg: rx_state_t enum (IDLE, START, DATA, STOP), DEFAULT_CLKS_PER_BIT=868, INSTR_BYTES=4, NOP_INSTR=32'h00000013 for benches.
- Sub-module uart_rx (synchronizer + RX FSM; outputs rx_byte[7:0], byte_valid, frame_err_pulse); top holds word assembly, address counter and completion logic.

Test Plan:
- Bytes B3,00,31,00 at 115200 baud -> single imem_we pulse, imem_addr=0, imem_wdata=32'h003100B3; then 93,00,20,00 -> addr=1, wdata=32'h00200093.
- Full 256-byte stream (2 words above + 62 NOPs) -> exactly 64 strobes, addr 0..63, words 2..63 = 32'h00000013; load_done=1, cpu_rst_n=1, loading=0 right after 64th strobe.
- Byte 55 with stop bit driven 0 -> frame_err=1, no byte counted; following 4 good bytes 01,02,03,04 -> wdata=32'h04030201.
- 200 ns low glitch on rxd while idle -> no byte_valid, frame_err stays 0.
- rst_n low for 100 ns after 2 bytes of word 5 -> all outputs to reset values; new stream restarts at addr 0, byte index 0.
- 4 extra bytes after load_done -> no imem_we, load_done and cpu_rst_n remain 1.
